// File: rtl/gpio_pad_pkg.sv
// ----------------------------------------------------------------------------
// gpio_pad_pkg
// Shared definitions for the GPIO pad-bank controller:
//   - register indices on the 3-bit register bus
//   - direction-sequencer FSM state encoding
//   - reset values for the register file and control flops
// ----------------------------------------------------------------------------
package gpio_pad_pkg;

  // Register indices
  localparam logic [2:0] ADDR_OUT      = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_PU       = 3'd2;
  localparam logic [2:0] ADDR_PD       = 3'd3;
  localparam logic [2:0] ADDR_IN       = 3'd4;
  localparam logic [2:0] ADDR_IRQ_EN   = 3'd5;
  localparam logic [2:0] ADDR_IRQ_STAT = 3'd6;
  localparam logic [2:0] ADDR_EDGE     = 3'd7;

  // Direction sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TURN = 1'b1
  } state_e;

  // Reset values: every register clears, so the whole bank comes up as inputs.
  // Wide enough for the largest bank; users slice the low N bits.
  localparam logic [31:0] RST_REG = 32'h0000_0000;
  localparam logic        RST_BIT = 1'b0;

endpackage

// File: rtl/gpio_sync_edge.sv
// ----------------------------------------------------------------------------
// gpio_sync_edge
// Synchronises a bank of asynchronous pad receive bits and produces gated
// single-cycle rising/falling event pulses.
//
// Ports:
//   clk     in   bank clock
//   rstn    in   asynchronous active-low reset
//   dc_i    in   W  raw pad receive data (asynchronous to clk)
//   ie_i    in   W  per-bit input enable; events are suppressed where low
//   in_o    out  W  synchronised receive data
//   rise_o  out  W  0->1 transition seen on in_o this cycle
//   fall_o  out  W  1->0 transition seen on in_o this cycle
// ----------------------------------------------------------------------------
module gpio_sync_edge
  import gpio_pad_pkg::*;
#(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] dc_i,
  input  logic [W-1:0] ie_i,
  output logic [W-1:0] in_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  // Stage 0 is the metastability-catching flop; stage SYNC-1 is the output.
  logic [SYNC-1:0][W-1:0] sync_q;
  logic [W-1:0]           dly_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      dly_q  <= RST_REG[W-1:0];
    end else begin
      sync_q <= {sync_q[SYNC-2:0], dc_i};
      dly_q  <= sync_q[SYNC-1];
    end
  end

  assign in_o = sync_q[SYNC-1];

  // Gating by the input enable keeps a pad that is driving, or sitting in its
  // turnaround window, from reporting its own activity as an input event.
  assign rise_o =  in_o & ~dly_q & ie_i;
  assign fall_o = ~in_o &  dly_q & ie_i;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// ----------------------------------------------------------------------------
// gpio_pad_ctrl
// Register-programmed controller for a bank of N bidirectional pad cells.
// Drives the pad control pins, samples the pad receive data through a
// synchroniser, raises edge interrupts, and sequences every direction change
// through a TA-cycle dead time with both driver and receiver disabled.
//
// Ports:
//   clk        in   bank clock
//   rstn       in   asynchronous active-low reset
//   req_valid  in   register request valid
//   req_ready  out  controller can accept a request (low during turnaround)
//   req_we     in   1=write, 0=read
//   req_addr   in   3  register index
//   req_wdata  in   N  write data
//   rsp_valid  out  read data valid, one-cycle pulse after acceptance
//   rsp_rdata  out  N  read data
//   irq        out  level interrupt, |(IRQ_STAT & IRQ_EN) registered
//   scan_en    in   scan mode request
//   pad_dc     in   N  per-pad receive data
//   pad_di     out  N  per-pad drive data
//   pad_oe     out  N  per-pad output enable
//   pad_ie     out  N  per-pad input enable
//   pad_pu     out  N  per-pad pull-up
//   pad_pd     out  N  per-pad pull-down
//   pad_sie    out  N  per-pad scan-in select
//   pad_soe    out  N  per-pad scan-out enable
// ----------------------------------------------------------------------------
module gpio_pad_ctrl
  import gpio_pad_pkg::*;
#(
  parameter int N    = 8,
  parameter int TA   = 2,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         irq,
  input  logic         scan_en,
  input  logic [N-1:0] pad_dc,
  output logic [N-1:0] pad_di,
  output logic [N-1:0] pad_oe,
  output logic [N-1:0] pad_ie,
  output logic [N-1:0] pad_pu,
  output logic [N-1:0] pad_pd,
  output logic [N-1:0] pad_sie,
  output logic [N-1:0] pad_soe
);

  // The counter holds TA-1 down to 0, so the sequencer spends exactly TA
  // cycles in TURN.
  localparam logic [3:0] TA_LOAD = 4'(TA - 1);

  // Register file
  logic [N-1:0] out_q,  out_d;
  logic [N-1:0] dir_q,  dir_d;
  logic [N-1:0] pu_q,   pu_d;
  logic [N-1:0] pd_q,   pd_d;
  logic [N-1:0] ien_q,  ien_d;
  logic [N-1:0] stat_q, stat_d;
  logic [N-1:0] edge_q, edge_d;

  // Direction sequencer
  state_e       state_q, state_d;
  logic [3:0]   cnt_q,   cnt_d;
  logic [N-1:0] chg_q,   chg_d;

  // Response, interrupt and scan flops
  logic         rsp_valid_q;
  logic [N-1:0] rsp_rdata_q, rsp_rdata_d;
  logic         irq_q;
  logic [1:0]   scan_q;

  // Input path
  logic [N-1:0] in_sync;
  logic [N-1:0] rise_ev;
  logic [N-1:0] fall_ev;
  logic [N-1:0] set_ev;
  logic [N-1:0] w1c;

  logic accept;
  logic wr_en;
  logic rd_en;
  logic dir_wr;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign wr_en     = accept & req_we;
  assign rd_en     = accept & ~req_we;
  assign dir_wr    = wr_en & (req_addr == ADDR_DIR);

  // ---------------------------------------------------------------------------
  // Direction sequencer: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      chg_q   <= RST_REG[N-1:0];
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Direction sequencer: next state
  // chg_q is nonzero only while in TURN, so it doubles as the active mask that
  // forces both enables low on the bits being turned around.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chg_d   = chg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dir_wr && (req_wdata != dir_q)) begin
          state_d = ST_TURN;
          cnt_d   = TA_LOAD;
          chg_d   = dir_q ^ req_wdata;
        end
      end
      ST_TURN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          chg_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        chg_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file next state and read mux
  // ---------------------------------------------------------------------------
  assign set_ev = (edge_q & rise_ev) | (~edge_q & fall_ev);
  assign w1c    = (wr_en && (req_addr == ADDR_IRQ_STAT)) ? req_wdata : '0;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    pu_d   = pu_q;
    pd_d   = pd_q;
    ien_d  = ien_q;
    edge_d = edge_q;
    if (wr_en) begin
      unique case (req_addr)
        ADDR_OUT:    out_d  = req_wdata;
        ADDR_DIR:    dir_d  = req_wdata;
        ADDR_PU:     pu_d   = req_wdata;
        ADDR_PD:     pd_d   = req_wdata;
        ADDR_IRQ_EN: ien_d  = req_wdata;
        ADDR_EDGE:   edge_d = req_wdata;
        default:     ;  // IN is read-only, IRQ_STAT handled as W1C below
      endcase
    end
    // A new event in the same cycle as its clear must not be lost.
    stat_d = (stat_q & ~w1c) | set_ev;
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    if (rd_en) begin
      unique case (req_addr)
        ADDR_OUT:      rsp_rdata_d = out_q;
        ADDR_DIR:      rsp_rdata_d = dir_q;
        ADDR_PU:       rsp_rdata_d = pu_q;
        ADDR_PD:       rsp_rdata_d = pd_q;
        ADDR_IN:       rsp_rdata_d = in_sync;
        ADDR_IRQ_EN:   rsp_rdata_d = ien_q;
        ADDR_IRQ_STAT: rsp_rdata_d = stat_q;
        ADDR_EDGE:     rsp_rdata_d = edge_q;
        default:       rsp_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q       <= RST_REG[N-1:0];
      dir_q       <= RST_REG[N-1:0];
      pu_q        <= RST_REG[N-1:0];
      pd_q        <= RST_REG[N-1:0];
      ien_q       <= RST_REG[N-1:0];
      stat_q      <= RST_REG[N-1:0];
      edge_q      <= RST_REG[N-1:0];
      rsp_valid_q <= RST_BIT;
      rsp_rdata_q <= RST_REG[N-1:0];
      irq_q       <= RST_BIT;
      scan_q      <= {RST_BIT, RST_BIT};
    end else begin
      out_q       <= out_d;
      dir_q       <= dir_d;
      pu_q        <= pu_d;
      pd_q        <= pd_d;
      ien_q       <= ien_d;
      stat_q      <= stat_d;
      edge_q      <= edge_d;
      rsp_valid_q <= rd_en;
      rsp_rdata_q <= rsp_rdata_d;
      // Interrupt follows the stored status, so it lags a status update by one.
      irq_q       <= |(stat_q & ien_q);
      scan_q      <= {scan_q[0], scan_en};
    end
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detection
  // pad_ie is a pure function of flops, so the gate it provides is glitch-free.
  // ---------------------------------------------------------------------------
  gpio_sync_edge #(
    .W    (N),
    .SYNC (SYNC)
  ) u_sync_edge (
    .clk    (clk),
    .rstn   (rstn),
    .dc_i   (pad_dc),
    .ie_i   (pad_ie),
    .in_o   (in_sync),
    .rise_o (rise_ev),
    .fall_o (fall_ev)
  );

  // ---------------------------------------------------------------------------
  // Pad control outputs
  // ---------------------------------------------------------------------------
  assign pad_oe    =  dir_q & ~chg_q;
  assign pad_ie    = ~dir_q & ~chg_q;
  assign pad_di    =  out_q & dir_q;
  assign pad_pu    =  pu_q;
  assign pad_pd    =  pd_q & ~pu_q;   // pull-up wins when both are requested
  assign pad_sie   = {N{scan_q[1]}};
  assign pad_soe   = {N{scan_q[1]}};

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign irq       = irq_q;

endmodule

// File: doc/gpio_pad_ctrl.md
Name: gpio_pad_ctrl

Overview:
- Register-programmed controller for a bank of N bidirectional pad cells.
- Drives each pad's control pins: di, oe, ie, pu, pd, sie, soe.
- Samples each pad's dc return through a synchroniser and raises edge interrupts.
- Sequences every direction change with a guaranteed dead time in which neither driver nor receiver is enabled. Sits between the SoC register bus and the pad ring.

Parameters:
- N, 8, number of pads in the bank (1..32).
- TA, 2, turnaround dead-time cycles on a direction change (1..15).
- SYNC, 2, synchroniser depth on pad_dc (2..3).

Ports:
- clk  in  1  bank clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  register request valid
- req_ready  out  1  controller can accept request
- req_we  in  1  1=write, 0=read
- req_addr  in  3  register index
- req_wdata  in  N  write data
- rsp_valid  out  1  read data valid, one-cycle pulse
- rsp_rdata  out  N  read data
- irq  out  1  level interrupt
- scan_en  in  1  scan mode request
- pad_dc  in  N  per-pad receive data
- pad_di  out  N  per-pad drive data
- pad_oe  out  N  per-pad output enable
- pad_ie  out  N  per-pad input enable
- pad_pu  out  N  per-pad pull-up
- pad_pd  out  N  per-pad pull-down
- pad_sie  out  N  per-pad scan-in select
- pad_soe  out  N  per-pad scan-out enable

Behaviour:
- Clock and reset: single clock clk; rstn asynchronous assert, active low. All flops reset.
- Register map:
  - 0 OUT (rw)
  - 1 DIR (rw, 1=output)
  - 2 PU (rw)
  - 3 PD (rw)
  - 4 IN (ro, synchronised dc)
  - 5 IRQ_EN (rw)
  - 6 IRQ_STAT (rw1c)
  - 7 EDGE (rw, 1=rising, 0=falling)
  - Writes to IN are ignored.
- Reset values:
  - All registers 0, so all pads are inputs.
  - pad_ie = all 1; pad_oe, pad_di, pad_pu, pad_pd, pad_sie, pad_soe = 0.
  - req_ready = 1; rsp_valid = 0, rsp_rdata = 0, irq = 0.
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - A write takes effect on the register at the accepting edge.
  - A read returns rsp_valid=1 with data exactly one cycle after acceptance.
  - The requester holds the request while req_ready=0.
- Direction FSM states:
  - IDLE: req_ready=1.
  - TURN: req_ready=0, counter loaded with TA-1.
- IDLE -> TURN on an accepted DIR write whose value differs from current DIR in at least one bit. The mask chg = old ^ new is latched.
  - From the edge after acceptance, chg bits have pad_oe=0 and pad_ie=0.
  - Bits not in chg are unaffected.
- TURN decrements the counter each cycle. At 0 it returns to IDLE, and in the same cycle chg bits take their new value: oe=DIR, ie=~DIR.
  - The dead time is exactly TA cycles with both enables low.
- A DIR write that equals current DIR completes like any other write, with no TURN.
- Output equations: pad_oe = DIR & ~chg_active; pad_ie = ~DIR & ~chg_active; pad_di = OUT & DIR.
- Pulls: pad_pu = PU; pad_pd = PD & ~PU, so pull-up wins when both are set.
- Scan: scan_en is registered through 2 flops and then fans out to all bits of pad_sie and pad_soe.
  - DIR, OUT and the FSM are unaffected by scan.
- Input path:
  - pad_dc passes through SYNC flops to give IN.
  - A one-flop-delayed copy of IN is used for edge detection.
  - Edge detect is gated by the registered pad_ie, so no events are seen during TURN or on outputs.
- IRQ_STAT: a bit is set on the selected edge.
  - W1C clears it.
  - If set and clear occur in the same cycle, set wins.
- irq is registered: irq = |(IRQ_STAT & IRQ_EN), one cycle after the status update.
- Reset mid-TURN: immediate return to IDLE; all pads become inputs.

Decomposition:
- Package gpio_pad_pkg holds:
  - register address localparams: ADDR_OUT .. ADDR_EDGE
  - FSM state enum: ST_IDLE, ST_TURN
  - reset-value constants
- One natural sub-module, gpio_sync_edge, per bank vector: holds the SYNC-stage synchroniser, the delay flop and the gated rising/falling pulse generation.

Test Plan:
- Reset:
  - Stimulus: release rstn.
  - Required: pad_ie=8'hFF, pad_oe=0, req_ready=1; reading addr 1 gives rsp_rdata=0 one cycle later.
- Input to output, TA=2:
  - Stimulus: write DIR=8'h01.
  - Required: pad_ie[0]=0 and pad_oe[0]=0 for exactly 2 cycles, req_ready=0 for those cycles, then pad_oe[0]=1.
  - Then write OUT=8'h01: pad_di[0]=1.
- Output to input:
  - Stimulus: from DIR=8'h01, write DIR=0.
  - Required: oe[0] drops next edge, ie[0] rises 2 cycles later. A read request issued during TURN stalls and completes after.
- Rising-edge interrupt:
  - Stimulus: EDGE=1, IRQ_EN=1, toggle pad_dc[0] 0->1.
  - Required: IRQ_STAT[0]=1 after SYNC+1 cycles, irq=1 one cycle later.
  - Then write IRQ_STAT=1: irq clears.
  - A simultaneous edge and W1C leaves the bit set.
- Pulls and scan:
  - Stimulus: PU=PD=8'h0F.
  - Required: pad_pu=8'h0F, pad_pd=0.
  - Stimulus: scan_en=1.
  - Required: pad_sie and pad_soe all 1 after 2 cycles, DIR unchanged.
- Async reset during TURN:
  - Required: FSM returns to IDLE, all pads inputs, req_ready=1 immediately.
